// File: rtl/stream_pe_fifo_pkg.sv
// Shared definitions for the stream PE-side FIFO slice.
package stream_pe_fifo_pkg;

  // Level of rst that holds the design in reset (active-low).
  localparam logic RESET_STATE = 1'b0;

endpackage

// File: rtl/fifo_core.sv
// Generic register-array FIFO: storage, pointers, occupancy, full/empty. No bypass path.
module fifo_core
  import stream_pe_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     occ_q, occ_d;
  logic              do_push, do_pop;

  assign full_o      = (occ_q == FullCnt);
  assign empty_o     = (occ_q == '0);
  assign occupancy_o = occ_q;
  assign do_push     = push_i & ~full_o;
  assign do_pop      = pop_i & ~empty_o;
  assign rdata_o     = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni == RESET_STATE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/stream_pe_fifo.sv
// Decoupling FIFO from a stream channel to its PE, with length tracking, done and overflow error.
module stream_pe_fifo
  import stream_pe_fifo_pkg::*;
#(
  parameter int unsigned STREAM_W = 24,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_L    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reset_execution,
  input  logic [CNT_L-1:0]       expected_len,
  input  logic [STREAM_W-1:0]    in_data,
  input  logic                   in_vld,
  output logic                   in_rdy,
  output logic [STREAM_W-1:0]    out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   done,
  output logic                   err
);

  logic             full, empty, push, pop;
  logic [CNT_L-1:0] accepted_cnt_q, delivered_cnt_q;
  logic             err_q;

  // in_rdy depends only on registered state, so a pop never frees a slot in the same cycle.
  assign in_rdy  = (rst != RESET_STATE) && !full;
  assign out_vld = !empty;
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  fifo_core #(
    .DATA_W(STREAM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (reset_execution),
    .push_i     (push),
    .wdata_i    (in_data),
    .pop_i      (pop),
    .rdata_o    (out_data),
    .full_o     (full),
    .empty_o    (empty),
    .occupancy_o(occupancy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_STATE) begin
      accepted_cnt_q  <= '0;
      delivered_cnt_q <= '0;
      err_q           <= 1'b0;
    end else if (reset_execution) begin
      accepted_cnt_q  <= '0;
      delivered_cnt_q <= '0;
      err_q           <= 1'b0;
    end else begin
      if (push && accepted_cnt_q != '1)  accepted_cnt_q  <= accepted_cnt_q + 1'b1;
      if (pop && delivered_cnt_q != '1) delivered_cnt_q <= delivered_cnt_q + 1'b1;
      // The overflowing word is still stored; only the sticky flag records it.
      if (push && accepted_cnt_q == expected_len) err_q <= 1'b1;
    end
  end

  assign done = (delivered_cnt_q == expected_len) && empty;
  assign err  = err_q;

  a_out_stable: assert property (@(posedge clk) disable iff (rst == RESET_STATE)
    (out_vld && !out_rdy && !reset_execution) |=> $stable(out_data))
    else $warning("out_data changed while stalled");

  a_no_push_full: assert property (@(posedge clk) disable iff (rst == RESET_STATE)
    full |-> !push)
    else $warning("push while full");

  a_len_stable: assert property (@(posedge clk) disable iff (rst == RESET_STATE)
    (!done && !reset_execution) |=> ($stable(expected_len) || reset_execution))
    else $warning("expected_len changed while executing");

endmodule

// File: tb/tb_stream_pe_fifo.sv
// Self-checking bench for stream_pe_fifo: vector table, scoreboard and corner-case sequences.
module tb_stream_pe_fifo;

  logic        clk;
  logic        rst;
  logic        reset_execution;
  logic [9:0]  expected_len;
  logic [23:0] in_data;
  logic        in_vld;
  logic        in_rdy;
  logic [23:0] out_data;
  logic        out_vld;
  logic        out_rdy;
  logic [2:0]  occupancy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [23:0] sb_q[$];

  stream_pe_fifo #(
    .STREAM_W(24),
    .DEPTH   (4),
    .CNT_L   (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .reset_execution(reset_execution),
    .expected_len   (expected_len),
    .in_data        (in_data),
    .in_vld         (in_vld),
    .in_rdy         (in_rdy),
    .out_data       (out_data),
    .out_vld        (out_vld),
    .out_rdy        (out_rdy),
    .occupancy      (occupancy),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard: inputs are stable at negedge, so this sees exactly what the next edge will see.
  always @(negedge clk) begin
    if (rst) begin
      if (reset_execution) begin
        sb_q.delete();
      end else begin
        if (out_vld && out_rdy) begin
          pops++;
          if (sb_q.size() == 0) check("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
          else check("sb_order", 32'(out_data), 32'(sb_q.pop_front()));
        end
        if (in_vld && in_rdy) sb_q.push_back(in_data);
      end
    end
  end

  typedef struct {
    logic        in_vld;
    logic [23:0] in_data;
    logic        out_rdy;
    logic        rexec;
    logic        in_rdy;
    logic        out_vld;
    logic [23:0] out_data;
    logic [2:0]  occ;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear(input logic [9:0] len);
    in_vld          = 1'b0;
    out_rdy         = 1'b0;
    expected_len    = len;
    reset_execution = 1'b1;
    step();
    reset_execution = 1'b0;
  endtask

  initial begin
    int nxt;
    int sent;
    int base;
    int early;
    int max_occ;
    logic will;

    rst = 1'b0; reset_execution = 1'b0; expected_len = 10'd0;
    in_vld = 1'b0; in_data = 24'h0; out_rdy = 1'b0;

    // Reset state
    #1;
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    check("post_rst_in_rdy", 32'(in_rdy), 32'd1);

    // Vector table, expected_len = 2
    vecs[0]  = '{1'b1, 24'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 24'hAA, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 24'hBB, 1'b0, 1'b0, 1'b1, 1'b1, 24'hAA, 3'd2, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 24'hCC, 1'b1, 1'b0, 1'b1, 1'b1, 24'hBB, 3'd2, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 24'h00, 1'b1, 1'b0, 1'b1, 1'b1, 24'hCC, 3'd1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 24'h00, 1'b1, 1'b0, 1'b1, 1'b0, 24'h00, 3'd0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 24'hDD, 1'b0, 1'b1, 1'b1, 1'b0, 24'h00, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 24'hEE, 1'b0, 1'b0, 1'b1, 1'b1, 24'hEE, 3'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 24'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 24'hEE, 3'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 24'h00, 1'b1, 1'b0, 1'b1, 1'b1, 24'hFF, 3'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 24'h00, 1'b1, 1'b0, 1'b1, 1'b0, 24'h00, 3'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 24'h00, 1'b0, 1'b0, 1'b1, 1'b0, 24'h00, 3'd0, 1'b1, 1'b0};
    clear(10'd2);
    for (int i = 0; i < 11; i++) begin
      in_vld = vecs[i].in_vld; in_data = vecs[i].in_data;
      out_rdy = vecs[i].out_rdy; reset_execution = vecs[i].rexec;
      step();
      check($sformatf("vec%0d_in_rdy", i), 32'(in_rdy), 32'(vecs[i].in_rdy));
      check($sformatf("vec%0d_out_vld", i), 32'(out_vld), 32'(vecs[i].out_vld));
      check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].out_data));
      check($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vecs[i].occ));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
    end
    reset_execution = 1'b0;

    // Streaming with no stall: one-cycle latency, occupancy stays at 1
    clear(10'd8);
    out_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_vld = 1'b1; in_data = 24'(k);
      step();
      check($sformatf("stream_vld%0d", k), 32'(out_vld), 32'd1);
      check($sformatf("stream_data%0d", k), 32'(out_data), 32'(k));
      check($sformatf("stream_occ%0d", k), 32'(occupancy), 32'd1);
      check($sformatf("stream_done%0d", k), 32'(done), 32'd0);
    end
    in_vld = 1'b0;
    step();
    check("stream_done", 32'(done), 32'd1);
    check("stream_err", 32'(err), 32'd0);

    // Stall until full, then release
    clear(10'd6);
    for (int k = 1; k <= 4; k++) begin
      in_vld = 1'b1; in_data = 24'(32'h100 + k);
      step();
      check($sformatf("stall_occ%0d", k), 32'(occupancy), 32'(k));
      check($sformatf("stall_in_rdy%0d", k), 32'(in_rdy), (k < 4) ? 32'd1 : 32'd0);
    end
    in_data = 24'h105;
    step();
    check("stall_held_occ", 32'(occupancy), 32'd4);
    check("stall_held_in_rdy", 32'(in_rdy), 32'd0);
    out_rdy = 1'b1;
    nxt = 5;
    for (int cyc = 0; cyc < 30 && !(nxt > 6 && !out_vld); cyc++) begin
      in_vld = (nxt <= 6);
      in_data = 24'(32'h100 + nxt);
      will = in_vld && in_rdy;
      step();
      if (will) nxt++;
      if (cyc == 0) begin
        check("stall_first_pop_occ", 32'(occupancy), 32'd3);
        check("stall_first_pop_in_rdy", 32'(in_rdy), 32'd1);
      end
    end
    in_vld = 1'b0;
    check("stall_drained", 32'(nxt > 6 && !out_vld), 32'd1);
    check("stall_done", 32'(done), 32'd1);

    // Random backpressure, 200 words
    clear(10'd200);
    sent = 0; base = pops; early = 0; max_occ = 0;
    for (int cyc = 0; cyc < 4000 && !(sent == 200 && pops - base == 200); cyc++) begin
      in_vld  = (sent < 200) && ($urandom_range(0, 1) == 1);
      in_data = 24'(32'h20_0000 + sent);
      out_rdy = ($urandom_range(0, 1) == 1);
      will = in_vld && in_rdy;
      step();
      if (will) sent++;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (done && (pops - base) < 200) early++;
    end
    in_vld = 1'b0; out_rdy = 1'b0;
    check("rand_all_popped", 32'(pops - base), 32'd200);
    check("rand_max_occ_le4", 32'(max_occ <= 4), 32'd1);
    check("rand_early_done", 32'(early), 32'd0);
    check("rand_done", 32'(done), 32'd1);

    // Overflow beyond expected_len
    clear(10'd3);
    for (int k = 1; k <= 4; k++) begin
      in_vld = 1'b1; in_data = 24'(32'h300 + k);
      step();
      check($sformatf("ovf_err%0d", k), 32'(err), (k == 4) ? 32'd1 : 32'd0);
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    base = pops;
    for (int k = 0; k < 4; k++) step();
    check("ovf_delivered", 32'(pops - base), 32'd4);
    check("ovf_occ", 32'(occupancy), 32'd0);
    check("ovf_done", 32'(done), 32'd0);
    check("ovf_err_sticky", 32'(err), 32'd1);

    // reset_execution with words buffered and a concurrent push
    clear(10'd2);
    for (int k = 1; k <= 3; k++) begin
      in_vld = 1'b1; in_data = 24'(32'h400 + k);
      step();
    end
    check("rexec_pre_occ", 32'(occupancy), 32'd3);
    check("rexec_pre_err", 32'(err), 32'd1);
    in_data = 24'h00DEAD; expected_len = 10'd0; reset_execution = 1'b1;
    step();
    reset_execution = 1'b0; in_vld = 1'b0;
    check("rexec_occ", 32'(occupancy), 32'd0);
    check("rexec_out_vld", 32'(out_vld), 32'd0);
    check("rexec_err", 32'(err), 32'd0);
    check("rexec_done", 32'(done), 32'd1);
    step();
    check("rexec_dropped", 32'(out_vld), 32'd0);

    // Async reset while full
    clear(10'd4);
    for (int k = 1; k <= 4; k++) begin
      in_vld = 1'b1; in_data = 24'(32'h500 + k);
      step();
    end
    in_vld = 1'b0;
    check("arst_pre_occ", 32'(occupancy), 32'd4);
    #2;
    rst = 1'b0; expected_len = 10'd0;
    #1;
    sb_q.delete();
    check("arst_out_vld", 32'(out_vld), 32'd0);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_in_rdy", 32'(in_rdy), 32'd0);
    check("arst_done", 32'(done), 32'd1);
    step();
    step();
    rst = 1'b1;
    step();
    check("arst_rel_in_rdy", 32'(in_rdy), 32'd1);
    check("arst_rel_done", 32'(done), 32'd1);
    check("arst_rel_occ", 32'(occupancy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
